apb_controller: RTL and testbench

Master-side sequencer for the AHB-to-APB bridge. It accepts one transfer request at a time from the bridge's AHB slave interface and decodes the address into a one-hot `Pselx`. It then drives the APB SETUP/ACCESS phases into `apb_interface`, handling `Pready` wait states with a bounded timeout. It returns read data and a completion/error pulse to the AHB side.

---
 rtl/apb_bridge_pkg.sv | 30 +++
 rtl/apb_addr_decode.sv | 33 +++
 rtl/apb_controller.sv | 129 ++++++++++++
 tb/tb_apb_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module : apb_bridge_pkg
// Brief  : Shared types and constants for the AHB-to-APB bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [31:0] c_region0_base  = 32'h8000_0000;
    localparam logic [31:0] c_region0_limit = 32'h83FF_FFFF;
    localparam logic [31:0] c_region1_base  = 32'h8400_0000;
    localparam logic [31:0] c_region1_limit = 32'h87FF_FFFF;
    localparam logic [31:0] c_region2_base  = 32'h8800_0000;
    localparam logic [31:0] c_region2_limit = 32'h8BFF_FFFF;

    localparam logic [2:0] c_psel_none = 3'b000;
    localparam logic [2:0] c_psel_s0   = 3'b001;
    localparam logic [2:0] c_psel_s1   = 3'b010;
    localparam logic [2:0] c_psel_s2   = 3'b100;

endpackage

`default_nettype wire

// File: rtl/apb_addr_decode.sv
//------------------------------------------------------------------------------
// Module : apb_addr_decode
// Brief  : Maps a 32-bit address onto a one-hot APB slave select.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_addr_decode
    import apb_bridge_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [2:0]  o_sel,
    output logic        o_mapped
);

    always_comb begin
        o_sel    = c_psel_none;
        o_mapped = 1'b0;
        if (i_addr >= c_region0_base && i_addr <= c_region0_limit) begin
            o_sel    = c_psel_s0;
            o_mapped = 1'b1;
        end else if (i_addr >= c_region1_base && i_addr <= c_region1_limit) begin
            o_sel    = c_psel_s1;
            o_mapped = 1'b1;
        end else if (i_addr >= c_region2_base && i_addr <= c_region2_limit) begin
            o_sel    = c_psel_s2;
            o_mapped = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_controller.sv
//------------------------------------------------------------------------------
// Module : apb_controller
// Brief  : APB master sequencer: request latch, SETUP/ACCESS FSM, timeout.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Req_valid,
    input  logic        Req_write,
    input  logic [31:0] Req_addr,
    input  logic [31:0] Req_wdata,
    output logic        Req_ready,
    input  logic        Pready,
    input  logic [31:0] Prdata,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Rsp_valid,
    output logic        Rsp_err,
    output logic [31:0] Rsp_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    apb_state_t        r_state, w_next;
    logic [2:0]        r_sel;
    logic [31:0]       r_addr, r_wdata, r_rdata;
    logic              r_write;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pend_err, r_rsp_valid, r_rsp_err;

    logic [2:0]        w_dec_sel;
    logic              w_dec_mapped;
    logic              w_req_ready, w_accept, w_done, w_timeout;
    logic              w_unm_idle, w_unm_access;

    apb_addr_decode u_decode (
        .i_addr   (Req_addr),
        .o_sel    (w_dec_sel),
        .o_mapped (w_dec_mapped)
    );

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (Req_valid && w_dec_mapped) w_next = ST_SETUP;
            end
            ST_SETUP: w_next = ST_ACCESS;
            ST_ACCESS: begin
                w_req_ready = Pready;
                if (Pready) begin
                    w_done = 1'b1;
                    w_next = (Req_valid && w_dec_mapped) ? ST_SETUP : ST_IDLE;
                end else if (TIMEOUT != 0 && r_cnt == c_cnt_last) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept     = Req_valid && w_req_ready;
    assign w_unm_idle   = w_accept && !w_dec_mapped && (r_state == ST_IDLE);
    assign w_unm_access = w_accept && !w_dec_mapped && (r_state == ST_ACCESS);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_sel       <= c_psel_none;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_pend_err  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && w_dec_mapped) begin
                r_sel   <= w_dec_sel;
                r_addr  <= Req_addr;
                r_wdata <= Req_wdata;
                r_write <= Req_write;
            end
            if (r_state == ST_SETUP)
                r_cnt <= '0;
            else if (r_state == ST_ACCESS && !Pready && r_cnt != c_cnt_max)
                r_cnt <= r_cnt + 1'b1;
            // An unmapped request taken on completion reports after the completion pulse;
            // the pending flag re-arms if another unmapped request lands while it drains.
            r_pend_err  <= w_unm_access || (r_pend_err && w_unm_idle);
            r_rsp_valid <= w_done || w_timeout || r_pend_err || w_unm_idle;
            r_rsp_err   <= w_timeout || r_pend_err || w_unm_idle;
            if (w_done && !r_write) r_rdata <= Prdata;
        end
    end

    // Gating with the reset keeps Req_ready low while reset is asserted.
    assign Req_ready = w_req_ready && Hresetn;
    assign Pselx     = (r_state == ST_SETUP || r_state == ST_ACCESS) ? r_sel : c_psel_none;
    assign Penable   = (r_state == ST_ACCESS);
    assign Pwrite    = r_write;
    assign Paddr     = r_addr;
    assign Pwdata    = r_wdata;
    assign Rsp_valid = r_rsp_valid;
    assign Rsp_err   = r_rsp_err;
    assign Rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_controller.sv
//------------------------------------------------------------------------------
// Module : tb_apb_controller
// Brief  : Directed self-checking bench for apb_controller (TIMEOUT = 4).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Req_valid, Req_write, Req_ready;
    logic [31:0] Req_addr, Req_wdata;
    logic        Pready;
    logic [31:0] Prdata;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, Pwdata;
    logic        Rsp_valid, Rsp_err;
    logic [31:0] Rsp_rdata;

    int checks   = 0;
    int failures = 0;

    apb_controller #(.TIMEOUT(4)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Req_valid (Req_valid),
        .Req_write (Req_write),
        .Req_addr  (Req_addr),
        .Req_wdata (Req_wdata),
        .Req_ready (Req_ready),
        .Pready    (Pready),
        .Prdata    (Prdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Rsp_valid (Rsp_valid),
        .Rsp_err   (Rsp_err),
        .Rsp_rdata (Rsp_rdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_psel"}, 32'(Pselx), 32'h0);
        check({tag, "_pen"},  32'(Penable), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Hresetn = 1'b0; Req_valid = 1'b0; Req_write = 1'b0;
        Req_addr = '0; Req_wdata = '0; Pready = 1'b0; Prdata = '0;
        #12;
        check("rst_ready", 32'(Req_ready), 32'h0);
        check("rst_rspv",  32'(Rsp_valid), 32'h0);
        check("rst_paddr", Paddr, 32'h0);
        idle_chk("rst");
        @(negedge Hclk); Hresetn = 1'b1;
        #1 check("post_rst_ready", 32'(Req_ready), 32'h1);

        // Read, zero wait states
        step();
        Req_valid = 1; Req_write = 0; Req_addr = 32'h8000_0010; Pready = 1; Prdata = 32'h1234_5678;
        #1 check("rd_ready_idle", 32'(Req_ready), 32'h1);
        step(); Req_valid = 0;
        #1;
        check("rd_setup_psel", 32'(Pselx), 32'h1);
        check("rd_setup_pen",  32'(Penable), 32'h0);
        check("rd_setup_paddr", Paddr, 32'h8000_0010);
        check("rd_setup_ready", 32'(Req_ready), 32'h0);
        step();
        check("rd_acc_psel", 32'(Pselx), 32'h1);
        check("rd_acc_pen",  32'(Penable), 32'h1);
        check("rd_acc_rspv", 32'(Rsp_valid), 32'h0);
        step();
        idle_chk("rd_done");
        check("rd_rspv",  32'(Rsp_valid), 32'h1);
        check("rd_rspe",  32'(Rsp_err), 32'h0);
        check("rd_rdata", Rsp_rdata, 32'h1234_5678);
        step();
        check("rd_rspv_end", 32'(Rsp_valid), 32'h0);

        // Write with 3 wait states
        Req_valid = 1; Req_write = 1; Req_addr = 32'h8400_0000; Req_wdata = 32'h8765_4321; Pready = 0;
        step(); Req_valid = 0; Req_wdata = 32'h0;
        #1;
        check("wr_setup_psel", 32'(Pselx), 32'h2);
        check("wr_setup_pwrite", 32'(Pwrite), 32'h1);
        check("wr_setup_pwdata", Pwdata, 32'h8765_4321);
        step();
        for (int i = 0; i < 3; i++) begin
            check("wr_wait_pen",   32'(Penable), 32'h1);
            check("wr_wait_psel",  32'(Pselx), 32'h2);
            check("wr_wait_pwdata", Pwdata, 32'h8765_4321);
            check("wr_wait_rspv",  32'(Rsp_valid), 32'h0);
            check("wr_wait_ready", 32'(Req_ready), 32'h0);
            step();
        end
        Pready = 1;
        #1;
        check("wr_last_pen",   32'(Penable), 32'h1);
        check("wr_last_ready", 32'(Req_ready), 32'h1);
        step();
        check("wr_rspv",  32'(Rsp_valid), 32'h1);
        check("wr_rspe",  32'(Rsp_err), 32'h0);
        check("wr_rdata", Rsp_rdata, 32'h1234_5678);
        idle_chk("wr_done");

        // Back-to-back reads
        Req_valid = 1; Req_write = 0; Req_addr = 32'h8800_0000; Prdata = 32'hAAAA_0001;
        step();
        Req_addr = 32'h8000_0000;
        #1 check("b2b_s1_psel", 32'(Pselx), 32'h4);
        step();
        check("b2b_a1_psel",  32'(Pselx), 32'h4);
        check("b2b_a1_pen",   32'(Penable), 32'h1);
        check("b2b_a1_ready", 32'(Req_ready), 32'h1);
        step();
        Req_valid = 0; Prdata = 32'hBBBB_0002;
        #1;
        check("b2b_s2_psel",  32'(Pselx), 32'h1);
        check("b2b_s2_pen",   32'(Penable), 32'h0);
        check("b2b_s2_paddr", Paddr, 32'h8000_0000);
        check("b2b_rsp1_v",   32'(Rsp_valid), 32'h1);
        check("b2b_rsp1_d",   Rsp_rdata, 32'hAAAA_0001);
        step();
        check("b2b_a2_psel", 32'(Pselx), 32'h1);
        check("b2b_a2_rspv", 32'(Rsp_valid), 32'h0);
        step();
        check("b2b_rsp2_v", 32'(Rsp_valid), 32'h1);
        check("b2b_rsp2_d", Rsp_rdata, 32'hBBBB_0002);
        idle_chk("b2b_done");

        // Unmapped address from IDLE
        Req_valid = 1; Req_addr = 32'h9000_0000;
        #1 check("unm_ready", 32'(Req_ready), 32'h1);
        step(); Req_valid = 0;
        #1;
        idle_chk("unm");
        check("unm_rspv",  32'(Rsp_valid), 32'h1);
        check("unm_rspe",  32'(Rsp_err), 32'h1);
        check("unm_ready2", 32'(Req_ready), 32'h1);
        step();
        check("unm_rspv_end", 32'(Rsp_valid), 32'h0);

        // Timeout
        Req_valid = 1; Req_addr = 32'h8000_0100; Pready = 0;
        step(); Req_valid = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("to_acc_pen",  32'(Penable), 32'h1);
            check("to_acc_rspv", 32'(Rsp_valid), 32'h0);
            step();
        end
        idle_chk("to_after");
        check("to_rspv",  32'(Rsp_valid), 32'h1);
        check("to_rspe",  32'(Rsp_err), 32'h1);
        check("to_rdata", Rsp_rdata, 32'hBBBB_0002);
        Req_valid = 1; Req_addr = 32'h8800_0004; Pready = 1; Prdata = 32'hCAFE_F00D;
        step(); Req_valid = 0;
        #1 check("to_next_psel", 32'(Pselx), 32'h4);
        step(); step();
        check("to_next_rspv",  32'(Rsp_valid), 32'h1);
        check("to_next_rspe",  32'(Rsp_err), 32'h0);
        check("to_next_rdata", Rsp_rdata, 32'hCAFE_F00D);

        // Unmapped request accepted on completion
        Req_valid = 1; Req_addr = 32'h8000_0000; Prdata = 32'h0000_5555;
        step();
        Req_addr = 32'h9000_0000;
        step();
        check("cu_acc_ready", 32'(Req_ready), 32'h1);
        step(); Req_valid = 0;
        #1;
        idle_chk("cu_idle");
        check("cu_rsp1_v", 32'(Rsp_valid), 32'h1);
        check("cu_rsp1_e", 32'(Rsp_err), 32'h0);
        check("cu_rsp1_d", Rsp_rdata, 32'h0000_5555);
        step();
        check("cu_rsp2_v", 32'(Rsp_valid), 32'h1);
        check("cu_rsp2_e", 32'(Rsp_err), 32'h1);
        step();
        check("cu_rsp_end", 32'(Rsp_valid), 32'h0);

        // Reset during ACCESS
        Req_valid = 1; Req_addr = 32'h8400_0040; Pready = 0;
        step(); Req_valid = 0;
        step();
        check("ra_pen_before", 32'(Penable), 32'h1);
        Hresetn = 0;
        #1;
        idle_chk("ra_async");
        check("ra_ready", 32'(Req_ready), 32'h0);
        check("ra_paddr", Paddr, 32'h0);
        check("ra_rdata", Rsp_rdata, 32'h0);
        @(negedge Hclk); Hresetn = 1;
        step();
        idle_chk("ra_release");
        check("ra_rspv",   32'(Rsp_valid), 32'h0);
        check("ra_ready2", 32'(Req_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
